status_bank: RTL and testbench
==============================

STATUS_BANK -- requirements
Module: status_bank

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 8: number of independent status channels (2..32).
REQ-002 The block SHALL take parameter CNT_WIDTH, default 4: width of each channel's saturating event counter.
REQ-003 Port clk SHALL be an input of width 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst SHALL be an input of width 1: reset, asynchronous and active-low.
REQ-005 Port set SHALL be an input of width CHANNELS: per-channel event strobe, one event per cycle high.
REQ-006 Port ack SHALL be an input of width CHANNELS: per-channel direct clear from the host side.
REQ-007 Port status SHALL be an output of width CHANNELS: per-channel pending flag.
REQ-008 Port tx_valid SHALL be an output of width 1: a report is offered.
REQ-009 Port tx_ready SHALL be an input of width 1: the consumer accepts the report.
REQ-010 Port tx_channel SHALL be an output of width clog2(CHANNELS): index of the reported channel.
REQ-011 Port tx_count SHALL be an output of width CNT_WIDTH: event count being reported.

Function
REQ-012 On set[i] without ack[i], cnt[i] SHALL increment, saturating at 2^CNT_WIDTH-1, and status[i] SHALL be 1 from the next cycle.
REQ-013 When ack[i] is high, cnt[i] and status[i] SHALL be 0 next cycle regardless of set[i] (ack wins).
REQ-014 status[i] SHALL equal (cnt[i] != 0) at all times.
REQ-015 The reporter FSM SHALL have states IDLE and PRESENT; tx_valid SHALL be 1 exactly in PRESENT.
REQ-016 In IDLE with any status bit set, the block SHALL select a channel round-robin, starting from the channel after the last reported one (channel 0 after reset), latch its index and cnt as a snapshot, and enter PRESENT next cycle.
REQ-017 tx_channel and tx_count SHALL hold the snapshot, stable, for the whole of PRESENT.
REQ-018 In PRESENT with tx_ready=1, the FSM SHALL return to IDLE; the reported channel's cnt SHALL become (live cnt - snapshot) + set that cycle, saturating.
REQ-019 Events on the reported channel during PRESENT SHALL therefore remain pending and SHALL NOT be lost.
REQ-020 If ack clears the presented channel during PRESENT, tx_valid SHALL stay high until handshake, and the residual count SHALL be 0, plus 1 if set is high in the handshake cycle.
REQ-021 Latency from set to tx_valid on an idle bank SHALL be 2 cycles; peak throughput SHALL be one report per 2 cycles.

Reset
REQ-022 On rst low, asynchronously: all cnt=0, status=0, FSM=IDLE, tx_valid=0, tx_channel=0, tx_count=0, round-robin pointer=0.
REQ-023 Reset asserted mid-PRESENT SHALL drop tx_valid immediately without a handshake.

Configuration
REQ-024 With STATUS_BANK_OVERFLOW_EN defined, the block SHALL add output overflow[CHANNELS]: overflow[i] is set when set[i] arrives while cnt[i] is saturated, and cleared by ack[i] or by the report handshake of channel i.
REQ-025 Without STATUS_BANK_OVERFLOW_EN, the overflow port and its logic SHALL be absent, and saturation SHALL be silent.

Structure
REQ-026 The FSM state encodings and the clog2 helper SHALL live in the shared tx_protocol package/header.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter: inputs request vector and last pointer; outputs grant index and any-grant.

Verification
REQ-028 Scenario: set[3] pulsed once, tx_ready=1 -> tx_valid 2 cycles later, tx_channel=3, tx_count=1; status[3]=0 after the handshake.
REQ-029 Scenario: set[0], set[5] and set[7] in the same cycle, tx_ready=1 -> reports are 0, 5, 7 in order, then channel 0 again only after a new set[0].
REQ-030 Scenario: set[2] for 20 cycles with CNT_WIDTH=4 and tx_ready=0 -> tx_count=1 is held stable; after tx_ready, the next report is channel 2 with count 15 (saturated); overflow[2]=1 when the macro is defined.
REQ-031 Scenario: set[1] and ack[1] in the same cycle -> status[1] stays 0 and no report is issued.
REQ-032 Scenario: ack[4] during PRESENT for channel 4 -> tx_valid stays high, the snapshot is delivered, and no further report is issued for channel 4.
REQ-033 Scenario: rst low during PRESENT -> tx_valid=0 within the same cycle and all status=0; after release, the bank behaves as fresh.

Source files
------------

// File: rtl/tx_protocol_pkg.sv
// Shared report-protocol definitions: reporter FSM encodings and a clog2 helper.
package tx_protocol_pkg;

  typedef enum logic {
    TX_IDLE    = 1'b0,
    TX_PRESENT = 1'b1
  } tx_state_e;

  // Index width for n channels, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v << 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requesting channel at or after ptr, wrapping; purely combinational.
module rr_arbiter
  import tx_protocol_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  int idx;

  // Scan from the far end so the channel closest to ptr is the last to write grant.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        grant = idx[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_bank.sv
// Per-channel saturating event counters with a round-robin reporter (set -> tx_valid in 2 cycles).
// Optional STATUS_BANK_OVERFLOW_EN adds a sticky per-channel overflow output.
module status_bank
  import tx_protocol_pkg::*;
#(
  parameter int CHANNELS  = 8,
  parameter int CNT_WIDTH = 4,
  parameter int IW        = clog2(CHANNELS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  set,
  input  logic [CHANNELS-1:0]  ack,
  output logic [CHANNELS-1:0]  status,
  output logic                 tx_valid,
  input  logic                 tx_ready,
`ifdef STATUS_BANK_OVERFLOW_EN
  output logic [CHANNELS-1:0]  overflow,
`endif
  output logic [IW-1:0]        tx_channel,
  output logic [CNT_WIDTH-1:0] tx_count
);

  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_d [CHANNELS];
  logic [CNT_WIDTH-1:0] base;
  tx_state_e            state_q;
  logic                 tx_valid_q;
  logic [IW-1:0]        tx_channel_q;
  logic [CNT_WIDTH-1:0] tx_count_q;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        grant;
  logic [IW-1:0]        ptr_nxt;
  logic                 any;
  logic                 hs;

  assign hs         = (state_q == TX_PRESENT) && tx_ready;
  assign tx_valid   = tx_valid_q;
  assign tx_channel = tx_channel_q;
  assign tx_count   = tx_count_q;
  assign ptr_nxt    = (grant == IW'(CHANNELS - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) status[i] = (cnt_q[i] != '0);
  end

  rr_arbiter #(.N(CHANNELS), .IW(IW)) u_arb (
    .req   (status),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  // On handshake only the reported snapshot is removed; later events stay pending.
  always_comb begin
    base = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ack[i]) begin
        cnt_d[i] = '0;
      end else if (hs && tx_channel_q == IW'(i)) begin
        base     = (cnt_q[i] > tx_count_q) ? cnt_q[i] - tx_count_q : '0;
        cnt_d[i] = (set[i] && base != CMAX) ? base + 1'b1 : base;
      end else if (set[i] && cnt_q[i] != CMAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TX_IDLE;
      tx_valid_q   <= 1'b0;
      tx_channel_q <= '0;
      tx_count_q   <= '0;
      ptr_q        <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (any) begin
            state_q      <= TX_PRESENT;
            tx_valid_q   <= 1'b1;
            tx_channel_q <= grant;
            tx_count_q   <= cnt_q[grant];
            ptr_q        <= ptr_nxt;
          end
        end
        TX_PRESENT: begin
          if (tx_ready) begin
            state_q    <= TX_IDLE;
            tx_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= TX_IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef STATUS_BANK_OVERFLOW_EN
  logic [CHANNELS-1:0] ovf_q, ovf_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ovf_d[i] = ovf_q[i];
      if (ack[i] || (hs && tx_channel_q == IW'(i))) ovf_d[i] = 1'b0;
      else if (set[i] && cnt_q[i] == CMAX)          ovf_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= '0;
    else      ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_status_bank.sv
// Directed bench for status_bank with default parameters (8 channels, 4-bit counters).
module tb_status_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] set;
  logic [7:0] ack;
  logic [7:0] status;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] tx_channel;
  logic [3:0] tx_count;
`ifdef STATUS_BANK_OVERFLOW_EN
  logic [7:0] overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  status_bank dut (
    .clk        (clk),
    .rst        (rst),
    .set        (set),
    .ack        (ack),
    .status     (status),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
`ifdef STATUS_BANK_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .tx_channel (tx_channel),
    .tx_count   (tx_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    set = '0; ack = '0; tx_ready = 1'b0; rst = 1'b0;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", tx_valid); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got=%0h exp=00", status); end
    checks++; if (tx_channel !== 3'd0) begin errors++; $display("FAIL reset_channel got=%0d exp=0", tx_channel); end
    checks++; if (tx_count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", tx_count); end
    rst = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%0b exp=0", tx_valid); end
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    set = 8'h08;
    tick();
    set = '0;
    checks++; if (status !== 8'h08) begin errors++; $display("FAIL single_status got=%0h exp=08", status); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%0b exp=0", tx_valid); end
    tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", tx_valid); end
    checks++; if (tx_channel !== 3'd3) begin errors++; $display("FAIL single_channel got=%0d exp=3", tx_channel); end
    checks++; if (tx_count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", tx_count); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_drop got=%0b exp=0", tx_valid); end
    checks++; if (status !== 8'h00) begin errors++; $display("FAIL single_cleared got=%0h exp=00", status); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_no_repeat got=%0b exp=0", tx_valid); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_ch [3];
    exp_ch[0] = 3'd0; exp_ch[1] = 3'd5; exp_ch[2] = 3'd7;
    apply_reset();
    tx_ready = 1'b1;
    set = 8'hA1;
    tick();
    set = '0;
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_channel !== exp_ch[n] || tx_count !== 4'd1) begin
        errors++; $display("FAIL rr_report%0d got=v%0b ch%0d cnt%0d exp=v1 ch%0d cnt1", n, tx_valid, tx_channel, tx_count, exp_ch[n]);
      end
      tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got=%0b exp=0", n, tx_valid); end
    end
    tick();
    checks++; if (tx_valid !== 1'b0 || status !== 8'h00) begin
      errors++; $display("FAIL rr_drained got=v%0b st%0h exp=v0 st00", tx_valid, status);
    end
    set = 8'h01;
    tick();
    set = '0;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_channel !== 3'd0) begin
      errors++; $display("FAIL rr_again got=v%0b ch%0d exp=v1 ch0", tx_valid, tx_channel);
    end
    tick();
  endtask

  task automatic test_saturate();
    tx_ready = 1'b0;
    set = 8'h04;
    for (int k = 1; k <= 20; k++) begin
      if (k == 20) tx_ready = 1'b1;
      tick();
      if (k >= 2 && k <= 19) begin
        checks++; if (tx_valid !== 1'b1 || tx_channel !== 3'd2 || tx_count !== 4'd1) begin
          errors++; $display("FAIL sat_hold%0d got=v%0b ch%0d cnt%0d exp=v1 ch2 cnt1", k, tx_valid, tx_channel, tx_count);
        end
      end
`ifdef STATUS_BANK_OVERFLOW_EN
      if (k == 19) begin
        checks++; if (overflow[2] !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%0b exp=1", overflow[2]); end
      end
`endif
    end
    set = '0;
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0 || status[2] !== 1'b1) begin
      errors++; $display("FAIL sat_handshake got=v%0b st%0b exp=v0 st1", tx_valid, status[2]);
    end
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_channel !== 3'd2 || tx_count !== 4'd15) begin
      errors++; $display("FAIL sat_second got=v%0b ch%0d cnt%0d exp=v1 ch2 cnt15", tx_valid, tx_channel, tx_count);
    end
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0 || status !== 8'h00) begin
      errors++; $display("FAIL sat_drained got=v%0b st%0h exp=v0 st00", tx_valid, status);
    end
  endtask

  task automatic test_set_ack_same();
    set = 8'h02; ack = 8'h02;
    tick();
    set = '0; ack = '0;
    checks++; if (status[1] !== 1'b0) begin errors++; $display("FAIL setack_status got=%0b exp=0", status[1]); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL setack_valid%0d got=%0b exp=0", k, tx_valid); end
    end
  endtask

  task automatic test_ack_present();
    tx_ready = 1'b0;
    set = 8'h10;
    tick();
    set = '0;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_channel !== 3'd4) begin
      errors++; $display("FAIL ackp_present got=v%0b ch%0d exp=v1 ch4", tx_valid, tx_channel);
    end
    ack = 8'h10;
    tick();
    ack = '0;
    checks++; if (tx_valid !== 1'b1 || tx_count !== 4'd1 || status[4] !== 1'b0) begin
      errors++; $display("FAIL ackp_hold got=v%0b cnt%0d st%0b exp=v1 cnt1 st0", tx_valid, tx_count, status[4]);
    end
    tx_ready = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ackp_handshake got=%0b exp=0", tx_valid); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (tx_valid !== 1'b0 || status !== 8'h00) begin
        errors++; $display("FAIL ackp_none%0d got=v%0b st%0h exp=v0 st00", k, tx_valid, status);
      end
    end
  endtask

  task automatic test_reset_present();
    tx_ready = 1'b0;
    set = 8'h41;
    tick();
    set = '0;
    tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rstp_present got=%0b exp=1", tx_valid); end
    rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || status !== 8'h00 || tx_channel !== 3'd0 || tx_count !== 4'd0) begin
      errors++; $display("FAIL rstp_async got=v%0b st%0h ch%0d cnt%0d exp=v0 st00 ch0 cnt0", tx_valid, status, tx_channel, tx_count);
    end
    #2;
    rst = 1'b1;
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstp_idle got=%0b exp=0", tx_valid); end
    set = 8'h42;
    tick();
    set = '0;
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_channel !== 3'd1 || tx_count !== 4'd1) begin
      errors++; $display("FAIL rstp_fresh got=v%0b ch%0d cnt%0d exp=v1 ch1 cnt1", tx_valid, tx_channel, tx_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_saturate();
    test_set_ack_same();
    test_ack_present();
    test_reset_present();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
